// File: rtl/tpu_host_pkg.sv
// Shared encodings and constants for the TPU host bridge.
package tpu_host_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StWait    = 3'd2,
        StCapture = 3'd3,
        StDrain   = 3'd4
    } state_e;

    localparam int unsigned N_LOAD_DEFAULT       = 8;
    localparam int unsigned N_OUT_DEFAULT        = 8;
    localparam int unsigned DONE_TIMEOUT_DEFAULT = 64;

    // Tile pin bit positions
    localparam int unsigned LOAD_EN_BIT    = 0;
    localparam int unsigned TRANSPOSE_BIT  = 1;
    localparam int unsigned ACTIVATION_BIT = 2;
    localparam int unsigned DONE_BIT       = 7;

    // Counter width able to hold the value `limit` itself.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return $clog2(limit) + 1;
    endfunction

endpackage

// File: rtl/tpu_host_bridge_result_buffer.sv
// Result capture buffer: written in capture order, read back in the same order.
module result_buffer #(
    parameter int unsigned Depth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     wr_en_i,
    input  logic [7:0]               wr_data_i,
    input  logic                     rd_adv_i,
    output logic [$clog2(Depth):0]   wr_idx_o,
    output logic [$clog2(Depth):0]   rd_idx_o,
    output logic [7:0]               rd_data_o
);
    localparam int unsigned IdxW  = $clog2(Depth) + 1;
    localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [7:0]      mem_q [Depth];
    logic [IdxW-1:0] wr_idx_q, rd_idx_q;

    // Storage: no reset needed, contents are only observed through rd_idx after writes.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_q[AddrW-1:0]] <= wr_data_i;
        end
    end

    // Write/read pointers; flush or reset empties the buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            if (wr_en_i) wr_idx_q <= wr_idx_q + 1'b1;
            if (rd_adv_i) rd_idx_q <= rd_idx_q + 1'b1;
        end
    end

    assign wr_idx_o  = wr_idx_q;
    assign rd_idx_o  = rd_idx_q;
    assign rd_data_o = mem_q[rd_idx_q[AddrW-1:0]];

endmodule

// File: rtl/tpu_host_bridge.sv
// Host sequencer: streams a job into the TPU tile, waits for done, captures and
// re-emits the result bytes as a valid/ready stream.
module tpu_host_bridge
    import tpu_host_pkg::*;
#(
    parameter int unsigned N_LOAD       = N_LOAD_DEFAULT,
    parameter int unsigned N_OUT        = N_OUT_DEFAULT,
    parameter int unsigned DONE_TIMEOUT = DONE_TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    input  logic       cfg_transpose,
    input  logic       cfg_activation,
    output logic [7:0] tpu_ui_in,
    output logic [7:0] tpu_uio_in,
    input  logic [7:0] tpu_uo_out,
    input  logic [7:0] tpu_uio_out,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready,
    output logic       busy,
    output logic       err
);
    localparam int unsigned LoadCntW = cnt_width(N_LOAD);
    localparam int unsigned WaitCntW = cnt_width(DONE_TIMEOUT);
    localparam int unsigned IdxW     = $clog2(N_OUT) + 1;

    state_e              state_q, state_d;
    logic [LoadCntW-1:0] load_cnt_q, load_cnt_d;
    logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0]          ui_q, ui_d;
    logic                load_en_q, load_en_d;
    logic                transpose_q, transpose_d;
    logic                activation_q, activation_d;
    logic                err_q, err_d;
    logic                s_ready_q, s_ready_d;

    logic                buf_wr_en, buf_flush, buf_rd_adv;
    logic [IdxW-1:0]     buf_wr_idx, buf_rd_idx;
    logic [7:0]          buf_rd_data;

    logic done, accept, unused_uio;

    assign done       = tpu_uio_out[DONE_BIT];
    assign unused_uio = ^tpu_uio_out[6:0];
    assign accept     = s_valid & s_ready_q;

    result_buffer #(
        .Depth (N_OUT)
    ) u_result_buffer (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (buf_flush),
        .wr_en_i   (buf_wr_en),
        .wr_data_i (tpu_uo_out),
        .rd_adv_i  (buf_rd_adv),
        .wr_idx_o  (buf_wr_idx),
        .rd_idx_o  (buf_rd_idx),
        .rd_data_o (buf_rd_data)
    );

    // Next-state logic and buffer control.
    always_comb begin
        state_d      = state_q;
        load_cnt_d   = load_cnt_q;
        wait_cnt_d   = '0;
        ui_d         = ui_q;
        load_en_d    = 1'b0;
        transpose_d  = transpose_q;
        activation_d = activation_q;
        err_d        = err_q;
        buf_wr_en    = 1'b0;
        buf_flush    = 1'b0;
        buf_rd_adv   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    transpose_d  = cfg_transpose;
                    activation_d = cfg_activation;
                    err_d        = 1'b0;
                    ui_d         = s_data;
                    load_en_d    = 1'b1;
                    load_cnt_d   = LoadCntW'(1);
                    state_d      = (N_LOAD == 1) ? StWait : StLoad;
                end
            end
            StLoad: begin
                if (accept) begin
                    ui_d       = s_data;
                    load_en_d  = 1'b1;
                    load_cnt_d = load_cnt_q + 1'b1;
                    if (load_cnt_q == LoadCntW'(N_LOAD - 1)) state_d = StWait;
                end
            end
            StWait: begin
                if (done) begin
                    buf_wr_en = 1'b1;
                    state_d   = (N_OUT == 1) ? StDrain : StCapture;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                    if (wait_cnt_q == WaitCntW'(DONE_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StCapture: begin
                if (done) begin
                    buf_wr_en = 1'b1;
                    if (buf_wr_idx == IdxW'(N_OUT - 1)) state_d = StDrain;
                end else begin
                    // Truncated result stream: drop the partial buffer.
                    err_d     = 1'b1;
                    buf_flush = 1'b1;
                    state_d   = StIdle;
                end
            end
            StDrain: begin
                if (m_ready) begin
                    buf_rd_adv = 1'b1;
                    if (buf_rd_idx == IdxW'(N_OUT - 1)) begin
                        buf_flush = 1'b1;
                        state_d   = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Config pins are only driven while a job is in flight.
        if (state_d == StIdle) begin
            transpose_d  = 1'b0;
            activation_d = 1'b0;
            load_cnt_d   = '0;
        end

        s_ready_d = (state_d == StIdle) || (state_d == StLoad);
    end

    // State and registered pin drivers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            load_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            ui_q         <= '0;
            load_en_q    <= 1'b0;
            transpose_q  <= 1'b0;
            activation_q <= 1'b0;
            err_q        <= 1'b0;
            s_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            load_cnt_q   <= load_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            ui_q         <= ui_d;
            load_en_q    <= load_en_d;
            transpose_q  <= transpose_d;
            activation_q <= activation_d;
            err_q        <= err_d;
            s_ready_q    <= s_ready_d;
        end
    end

    // Tile-side pin assembly.
    always_comb begin
        tpu_uio_in                 = '0;
        tpu_uio_in[LOAD_EN_BIT]    = load_en_q;
        tpu_uio_in[TRANSPOSE_BIT]  = transpose_q;
        tpu_uio_in[ACTIVATION_BIT] = activation_q;
    end

    assign tpu_ui_in = ui_q;
    assign s_ready   = s_ready_q;
    assign busy      = (state_q != StIdle);
    assign err       = err_q;
    assign m_valid   = (state_q == StDrain);
    assign m_data    = m_valid ? buf_rd_data : 8'h00;
    assign m_last    = m_valid && (buf_rd_idx == IdxW'(N_OUT - 1));

endmodule

// File: tb/tb_tpu_host_bridge.sv
// Scoreboard bench for tpu_host_bridge with a simple behavioural tile.
module tb_tpu_host_bridge;
    localparam int unsigned Timeout = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [7:0] s_data = '0;
    logic       s_ready;
    logic       cfg_transpose = 1'b0;
    logic       cfg_activation = 1'b0;
    logic [7:0] tpu_ui_in, tpu_uio_in;
    logic [7:0] tpu_uo_out = '0;
    logic [7:0] tpu_uio_out = '0;
    logic       m_valid, m_last;
    logic [7:0] m_data;
    logic       m_ready = 1'b1;
    logic       busy, err;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses   = 0;
    int mr_mode  = 0;
    int mr_idx   = 0;
    logic [1:0] exp_cfg = '0;        // {activation, transpose}
    logic [7:0] ld_q [$];            // bytes expected on the tile load pins
    logic [8:0] res_q [$];           // {last, data} expected on the result stream
    logic [7:0] job_ld [8];
    logic [7:0] job_res [8];

    always #5 clk = ~clk;

    tpu_host_bridge #(
        .N_LOAD       (8),
        .N_OUT        (8),
        .DONE_TIMEOUT (Timeout)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .cfg_transpose  (cfg_transpose),
        .cfg_activation (cfg_activation),
        .tpu_ui_in      (tpu_ui_in),
        .tpu_uio_in     (tpu_uio_in),
        .tpu_uo_out     (tpu_uo_out),
        .tpu_uio_out    (tpu_uio_out),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_ready        (m_ready),
        .busy           (busy),
        .err            (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_s_ready"}, 32'(s_ready), 0);
        chk({tag, "_ui_in"}, 32'(tpu_ui_in), 0);
        chk({tag, "_uio_in"}, 32'(tpu_uio_in), 0);
        chk({tag, "_m_valid"}, 32'(m_valid), 0);
        chk({tag, "_m_data"}, 32'(m_data), 0);
        chk({tag, "_m_last"}, 32'(m_last), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_err"}, 32'(err), 0);
    endtask

    // Result monitor: every valid cycle must match the head of the expected stream.
    always @(negedge clk) begin
        if (!rst && m_valid) begin
            if (res_q.size() == 0) begin
                chk("m_valid_unexpected", 32'(m_valid), 0);
            end else begin
                chk("m_data", 32'(m_data), 32'(res_q[0][7:0]));
                chk("m_last", 32'(m_last), 32'(res_q[0][8]));
                if (m_ready) void'(res_q.pop_front());
            end
        end
    end

    // Tile-side monitor: each load_en cycle consumes one expected job byte.
    always @(negedge clk) begin
        if (!rst && tpu_uio_in[0]) begin
            pulses++;
            if (ld_q.size() == 0) begin
                chk("load_en_unexpected", 32'(tpu_uio_in[0]), 0);
            end else begin
                chk("load_byte", 32'(tpu_ui_in), 32'(ld_q.pop_front()));
                chk("load_uio", 32'(tpu_uio_in), 32'({5'b0, exp_cfg, 1'b1}));
            end
        end
    end

    // Result consumer ready pattern.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            mr_idx++;
            case (mr_mode)
                0: m_ready = 1'b1;
                1: m_ready = ((mr_idx % 4) == 0) || ((mr_idx % 4) == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                chk("s_ready_timeout", 32'(s_ready), 1);
                break;
            end
        end
        ld_q.push_back(b);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic load_job(input logic trn, input logic act, input int gap_after,
                            input int gap_len, input logic chk_err_clear);
        exp_cfg = {act, trn};
        pulses  = 0;
        cfg_transpose  = trn;
        cfg_activation = act;
        for (int i = 0; i < 8; i++) begin
            send_byte(job_ld[i]);
            if (i == 0) begin
                // Scramble config to show it was latched on byte 0.
                cfg_transpose  = 1'($urandom_range(0, 1));
                cfg_activation = 1'($urandom_range(0, 1));
                if (chk_err_clear) chk("err_cleared_on_accept", 32'(err), 0);
            end
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk);
                    #1;
                    chk("gap_ui_hold", 32'(tpu_ui_in), 32'(job_ld[i]));
                    chk("gap_load_en_low", 32'(tpu_uio_in[0]), 0);
                end
            end
        end
    endtask

    task automatic tile_done(input int delay, input int len);
        for (int d = 0; d < delay; d++) begin
            @(posedge clk);
            #1;
            if (d == 0) chk("wait_uio", 32'(tpu_uio_in), 32'({5'b0, exp_cfg, 1'b0}));
        end
        for (int i = 0; i < len; i++) begin
            tpu_uio_out = {1'b1, 7'($urandom)};
            tpu_uo_out  = (i < 8) ? job_res[i] : 8'($urandom);
            if (len >= 8 && i < 8) res_q.push_back({(i == 7), job_res[i]});
            @(posedge clk);
            #1;
        end
        tpu_uio_out = {1'b0, 7'($urandom)};
        tpu_uo_out  = 8'($urandom);
    endtask

    task automatic wait_drained(input string tag);
        int k = 0;
        while (res_q.size() != 0 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, "_drain_left"}, 32'(res_q.size()), 0);
        res_q.delete();
        chk({tag, "_busy_after_last"}, 32'(busy), 0);
        chk({tag, "_load_pulses"}, 32'(pulses), 8);
    endtask

    task automatic rand_job_data();
        for (int i = 0; i < 8; i++) begin
            job_ld[i]  = 8'($urandom);
            job_res[i] = 8'($urandom);
        end
    endtask

    initial begin
        int k;
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("s_ready_after_reset", 32'(s_ready), 1);

        // Continuous job with fixed bytes
        for (int i = 0; i < 8; i++) begin
            job_ld[i]  = 8'(i + 1);
            job_res[i] = 8'(8'hAA + i);
        end
        load_job(1'b1, 1'b0, -1, 0, 1'b0);
        tile_done(1, 8);
        wait_drained("continuous");

        // Gapped load: 3 idle cycles after byte 4
        rand_job_data();
        load_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3, 3, 1'b0);
        tile_done(0, 8);
        wait_drained("gapped");

        // Backpressure 1,0,0,1,...
        mr_mode = 1;
        rand_job_data();
        load_job(1'b0, 1'b1, -1, 0, 1'b0);
        tile_done(2, 8);
        wait_drained("backpressure");
        mr_mode = 0;

        // Timeout: done never rises
        rand_job_data();
        load_job(1'b1, 1'b1, -1, 0, 1'b0);
        k = 0;
        while (!err && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("timeout_cycles", 32'(k), Timeout);
        chk("timeout_busy", 32'(busy), 0);
        chk("timeout_pulses", 32'(pulses), 8);
        @(posedge clk);
        #1;
        chk("err_sticky", 32'(err), 1);
        rand_job_data();
        load_job(1'b0, 1'b0, -1, 0, 1'b1);
        tile_done(0, 8);
        wait_drained("after_timeout");

        // Short done: 5 cycles only
        rand_job_data();
        load_job(1'b1, 1'b0, -1, 0, 1'b0);
        tile_done(0, 5);
        @(posedge clk);
        #1;
        chk("short_err", 32'(err), 1);
        chk("short_busy", 32'(busy), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("short_no_results", 32'(m_valid), 0);

        // Reset after 3 captured bytes
        rand_job_data();
        load_job(1'b1, 1'b1, -1, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tpu_uio_out = {1'b1, 7'($urandom)};
            tpu_uo_out  = job_res[i];
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("rst_capture");
        rst         = 1'b0;
        tpu_uio_out = '0;
        @(posedge clk);
        #1;
        chk("rst_capture_s_ready", 32'(s_ready), 1);
        rand_job_data();
        load_job(1'b0, 1'b1, -1, 0, 1'b0);
        tile_done(1, 8);
        wait_drained("after_reset");

        // Randomised jobs
        for (int j = 0; j < 6; j++) begin
            mr_mode = $urandom_range(0, 2);
            rand_job_data();
            load_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(0, 7), $urandom_range(0, 3), 1'b0);
            tile_done($urandom_range(0, 10), $urandom_range(8, 11));
            wait_drained("random");
        end
        mr_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
